cp0: RTL and testbench
======================

# cp0

Coprocessor-0 register file and exception/interrupt arbiter for the MIPS pipeline, at the stage where the control decoder resolves COP0 instructions. It holds SR, Cause, EPC and PrID, samples hardware interrupt lines, and raises `INT_REQ` toward the decoder, which redirects the PC to the handler. It services `mfc0` reads, `mtc0` writes and `eret` from the decoder, and records EPC/Cause when a trap is taken.

## Interface
- `PRID`, 32'h4D49_5053, constant value returned by register 15.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (sampled on `clk`).
- `A1`  in  5  read address (`rd` field of `mfc0`).
- `A2`  in  5  write address (`rd` field of `mtc0`).
- `DIn`  in  32  `mtc0` write data.
- `WE`  in  1  `mtc0` write strike.
- `Eret`  in  1  `eret` being executed this cycle.
- `PC`  in  32  PC of the instruction in the trapping stage.
- `BD`  in  1  instruction at `PC` is in a branch delay slot.
- `Exc_Req`  in  1  synchronous exception from the decoder or datapath (illegal opcode, overflow, address error).
- `ExcCode_In`  in  5  code for `Exc_Req`.
- `HWInt`  in  6  hardware interrupt lines, synchronous to `clk`, level-sensitive.
- `INT_REQ`  out  1  trap taken this cycle; the decoder forces PC to the handler.
- `EPC`  out  32  current EPC register, the `eret` target.
- `DOut`  out  32  read data for `A1`.

## Operation
- SR (reg 12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
- Cause (reg 13): BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
- EPC (reg 14): 32 bits, bits [1:0] always 0.
- PrID (reg 15): returns `PRID`.
- Unimplemented addresses read 0; writes to them are dropped.
- `irq = IE & |(IP_next & IM)`, where `IP_next = HWInt`.
- `INT_REQ = reset & !EXL & (irq | Exc_Req)`.
- Interrupts take priority over `Exc_Req` when both are present.
- Trap-taken edge (`INT_REQ`=1):
  - EXL set to 1.
  - EPC set to `(BD ? PC-4 : PC) & ~3`.
  - Cause.BD set to `BD`.
  - Cause.ExcCode set to 0 for an interrupt, otherwise `ExcCode_In`.
- `Eret` (when `INT_REQ`=0): EXL cleared at the edge.
- `mtc0` (`WE`=1, `INT_REQ`=0):
  - A2=12: writes IM, EXL and IE from `DIn`.
  - A2=14: writes `DIn & ~3`.
  - A2=13 or 15: ignored.
- Cause.IP loads `HWInt` every cycle regardless of mask, including while EXL=1.
- Priority on one edge: trap > `Eret` > `mtc0`. A trap in the same cycle as `WE` or `Eret` suppresses both.
- `Exc_Req` while EXL=1 is ignored; no nested traps.

## Timing
- Reset (`reset`=0 at an edge) loads SR=0, Cause=0, EPC=0. While `reset`=0, `INT_REQ`=0.
- Output values after reset: `EPC`=0; `DOut` = 0, or `PRID` for A1=15.
- `DOut`, `EPC` and `INT_REQ` are combinational from current registers and inputs; zero-cycle latency.
- No write-through: an `mtc0` becomes visible on `DOut`/`EPC` the cycle after its edge.
- An `eret` in the cycle after an `mtc0` to EPC returns to the new value.
- The trap updates EXL, EPC and Cause one edge after `INT_REQ` is high. `INT_REQ` drops the cycle after, because EXL=1.
- A pending masked-in interrupt during `Eret` re-traps one cycle after the `eret` edge; EPC then holds the handler-return PC.
- An IE or IM enable by `mtc0` takes effect the cycle after the write.

## Structure
- Shared package `cp0_pkg`:
  - register addresses 12–15;
  - field bit positions for IM, EXL, IE, BD, IP and ExcCode;
  - ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
- Single flat module with no sub-module; the register set and arbiter are too small to split.

## Test plan
- Reset then read all registers: A1=12/13/14 -> `DOut`=0; A1=15 -> `PRID`; `INT_REQ`=0.
- Interrupt enable: `mtc0` SR=32'h0000_0401, then `HWInt`=6'b000001, PC=32'h0000_3010 -> `INT_REQ`=1 that cycle. Next cycle: EXL=1, EPC=32'h0000_3010, Cause=32'h0000_0400, `INT_REQ`=0.
- Delay slot: `Exc_Req`=1, ExcCode_In=12, BD=1, PC=32'h0000_3024 -> EPC=32'h0000_3020, Cause=32'h8000_0030.
- `eret` with HWInt still high: EXL clears, then `INT_REQ`=1 the following cycle. With HWInt low, no retrap.
- Masking: IE=1, IM=0, HWInt=6'h3F -> `INT_REQ`=0 and Cause.IP=6'h3F. Likewise EXL=1 with `Exc_Req`=1 -> `INT_REQ`=0.
- Collision: `WE`=1 A2=14 DIn=32'h1234_5677 in the same cycle as a trap at PC=32'h0000_3000 -> EPC=32'h0000_3000. The same write without a trap -> EPC=32'h1234_5674.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 block: register addresses, field
// positions, implemented-bit masks and exception codes.
package cp0_pkg;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;
  localparam int IP_HI   = 15;
  localparam int IP_LO   = 10;
  localparam int EXC_HI  = 6;
  localparam int EXC_LO  = 2;

  // Bits that physically exist; everything else reads back as 0.
  localparam logic [31:0] SR_MASK    = 32'h0000_FC03;
  localparam logic [31:0] CAUSE_MASK = 32'h8000_FC7C;
  localparam logic [31:0] PRID_VAL   = 32'h4D49_5053;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PrID register file plus the trap arbiter that
// raises INT_REQ toward the decoder and records EPC/Cause on the trap edge.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = PRID_VAL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic        Eret,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic        Exc_Req,
  input  logic [4:0]  ExcCode_In,
  input  logic [5:0]  HWInt,
  output logic        INT_REQ,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  logic [31:0] sr_q, sr_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        irq;

  always_comb begin
    irq     = sr_q[IE_BIT] & |(HWInt & sr_q[IM_HI:IM_LO]);
    INT_REQ = reset & ~sr_q[EXL_BIT] & (irq | Exc_Req);

    sr_d    = sr_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    // IP tracks the raw lines every cycle, independent of mask and EXL.
    cause_d[IP_HI:IP_LO] = HWInt;

    if (INT_REQ) begin
      sr_d[EXL_BIT]          = 1'b1;
      epc_d                  = (BD ? PC - 32'd4 : PC) & ~32'h3;
      cause_d[BD_BIT]        = BD;
      cause_d[EXC_HI:EXC_LO] = irq ? 5'(EXC_INT) : ExcCode_In;
    end else if (Eret) begin
      sr_d[EXL_BIT] = 1'b0;
    end else if (WE) begin
      case (A2)
        ADDR_SR:  sr_d  = DIn & SR_MASK;
        ADDR_EPC: epc_d = DIn & ~32'h3;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      sr_q    <= sr_d & SR_MASK;
      cause_q <= cause_d & CAUSE_MASK;
      epc_q   <= epc_d;
    end
  end

  assign EPC = epc_q;

  always_comb begin
    DOut = '0;
    case (A1)
      ADDR_SR:    DOut = sr_q;
      ADDR_CAUSE: DOut = cause_q;
      ADDR_EPC:   DOut = epc_q;
      ADDR_PRID:  DOut = PRID;
      default:    DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// Bench for cp0: a word-level model of the architectural registers is checked
// against the DUT every cycle, plus literal expectations from the test plan.
module tb_cp0;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCode_In;
  logic [31:0] DIn, PC;
  logic        WE, Eret, BD, Exc_Req;
  logic [5:0]  HWInt;
  logic        INT_REQ;
  logic [31:0] EPC, DOut;

  localparam logic [31:0] PRID_C = 32'h4D49_5053;

  int checks = 0;
  int errors = 0;

  // Model state as whole architectural words.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0 dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .Eret(Eret), .PC(PC), .BD(BD), .Exc_Req(Exc_Req),
    .ExcCode_In(ExcCode_In), .HWInt(HWInt), .INT_REQ(INT_REQ),
    .EPC(EPC), .DOut(DOut)
  );

  always #5 clk = ~clk;

  function automatic logic m_irq();
    logic [5:0] im;
    im = m_sr[15:10];
    return m_sr[0] && ((HWInt & im) != 6'd0);
  endfunction

  function automatic logic m_int();
    return reset && !m_sr[1] && (m_irq() || Exc_Req);
  endfunction

  function automatic logic [31:0] m_dout();
    case (A1)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_C;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Compare at the falling edge, then advance the model across the rising edge.
  task automatic cyc();
    logic [31:0] ret;
    @(negedge clk);
    chk("INT_REQ", {31'd0, INT_REQ}, {31'd0, m_int()});
    chk("EPC", EPC, m_epc);
    chk("DOut", DOut, m_dout());
    @(posedge clk);
    if (!reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause = {m_cause[31:16], HWInt, m_cause[9:0]};
      if (m_int()) begin
        ret = BD ? PC - 32'd4 : PC;
        m_epc = {ret[31:2], 2'b00};
        m_cause[31] = BD;
        m_cause[6:2] = m_irq() ? 5'd0 : ExcCode_In;
        m_sr[1] = 1'b1;
      end else if (Eret) begin
        m_sr[1] = 1'b0;
      end else if (WE && A2 == 5'd12) begin
        m_sr = {16'd0, DIn[15:10], 8'd0, DIn[1:0]};
      end else if (WE && A2 == 5'd14) begin
        m_epc = {DIn[31:2], 2'b00};
      end
    end
    #1;
  endtask

  task automatic lit(input string name, input logic [4:0] a, input logic [31:0] exp);
    A1 = a;
    #1;
    chk(name, DOut, exp);
  endtask

  initial begin
    reset = 0; A1 = 0; A2 = 0; DIn = 0; WE = 0; Eret = 0; PC = 0;
    BD = 0; Exc_Req = 1; ExcCode_In = 5'd10; HWInt = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    @(posedge clk); #1;
    cyc(); cyc();
    chk("int_in_reset", {31'd0, INT_REQ}, 32'd0);
    Exc_Req = 0;
    lit("rst_sr", 5'd12, 32'd0);
    lit("rst_cause", 5'd13, 32'd0);
    lit("rst_epc", 5'd14, 32'd0);
    lit("rst_prid", 5'd15, PRID_C);
    chk("rst_epc_port", EPC, 32'd0);

    // Enable IM[0]/IE, then raise line 0.
    reset = 1;
    WE = 1; A2 = 5'd12; DIn = 32'h0000_0401; cyc(); WE = 0;
    HWInt = 6'b000001; PC = 32'h0000_3010; #1;
    chk("irq_taken", {31'd0, INT_REQ}, 32'd1);
    cyc();
    lit("trap_sr", 5'd12, 32'h0000_0403);
    lit("trap_cause", 5'd13, 32'h0000_0400);
    chk("trap_epc", EPC, 32'h0000_3010);
    chk("trap_int_drop", {31'd0, INT_REQ}, 32'd0);

    // eret with the line still asserted re-traps next cycle.
    Eret = 1; cyc(); Eret = 0; #1;
    chk("retrap", {31'd0, INT_REQ}, 32'd1);
    cyc();
    HWInt = 0; Eret = 1; cyc(); Eret = 0; #1;
    chk("no_retrap", {31'd0, INT_REQ}, 32'd0);
    lit("eret_sr", 5'd12, 32'h0000_0401);

    // Overflow in a branch delay slot.
    Exc_Req = 1; ExcCode_In = 5'd12; BD = 1; PC = 32'h0000_3024; cyc();
    Exc_Req = 0; BD = 0; #1;
    chk("bd_epc", EPC, 32'h0000_3020);
    lit("bd_cause", 5'd13, 32'h8000_0030);
    Exc_Req = 1; ExcCode_In = 5'd4; #1;
    chk("no_nest", {31'd0, INT_REQ}, 32'd0);
    cyc(); Exc_Req = 0; #1;
    chk("no_nest_epc", EPC, 32'h0000_3020);
    Eret = 1; cyc(); Eret = 0;

    // IE on, IM off: lines show in IP but never trap.
    WE = 1; A2 = 5'd12; DIn = 32'h0000_0001; cyc(); WE = 0;
    HWInt = 6'h3F; #1;
    chk("masked", {31'd0, INT_REQ}, 32'd0);
    cyc();
    lit("masked_ip", 5'd13, 32'h8000_FC30);
    HWInt = 0;

    // mtc0 EPC colliding with a trap is dropped.
    Exc_Req = 1; ExcCode_In = 5'd10; PC = 32'h0000_3000;
    WE = 1; A2 = 5'd14; DIn = 32'h1234_5677; cyc();
    WE = 0; Exc_Req = 0; #1;
    chk("collide_epc", EPC, 32'h0000_3000);
    Eret = 1; cyc(); Eret = 0;
    WE = 1; A2 = 5'd14; DIn = 32'h1234_5677; #1;
    chk("no_writethru", EPC, 32'h0000_3000);
    cyc(); WE = 0; #1;
    chk("mtc0_epc", EPC, 32'h1234_5674);

    // Writes to Cause/PrID ignored; Eret beats a same-cycle mtc0.
    WE = 1; A2 = 5'd13; DIn = 32'hFFFF_FFFF; cyc();
    A2 = 5'd15; cyc();
    A2 = 5'd12; Eret = 1; cyc(); Eret = 0; WE = 0;
    lit("eret_beats_wr", 5'd12, 32'h0000_0001);
    lit("unimpl", 5'd3, 32'd0);

    // Directed table of mixed traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 40; i++) begin
      A1 = 5'(12 + (i % 5));
      A2 = (i % 3 == 0) ? 5'd12 : 5'd14;
      DIn = 32'h0000_FC03 ^ (32'h0101_0100 * 32'(i));
      WE = (i % 4 == 1);
      Eret = (i % 6 == 5);
      Exc_Req = (i % 7 == 3);
      ExcCode_In = 5'(i);
      BD = i[0];
      PC = 32'h0000_4000 + 32'(i * 4) + 32'(i % 3);
      HWInt = 6'(i * 5);
      reset = (i != 30);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
